reorder_bank_ctrl: RTL and testbench
====================================

Name: reorder_bank_ctrl

Overview:
- Controller that sequences a 2-port RAM (1-cycle registered read, write-first-cycle semantics irrelevant, banks never collide) as a double-buffered reorder buffer.
- Producer writes entries out of order, tagged by index, into the fill bank.
- When every index of the bank has been written, the banks swap and the full bank is drained in index order 0..BANK_DEPTH-1 through a valid/ready output.
- Sits between the out-of-order source and the in-order consumer, driving the RAM's port signals.

Parameters:
- DW, 18, data width (matches RAM).
- AW, 7, RAM address width; MSB selects bank, BANK_DEPTH = 2**(AW-1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_vld  in  1  write request valid
- in_rdy  out  1  fill bank accepts writes
- in_idx  in  AW-1  reorder index within bank
- in_data  in  DW  write data
- out_vld  out  1  ordered output valid
- out_rdy  in  1  consumer accepts
- out_data  out  DW  ordered output data
- dup_err  out  1  one-cycle pulse: duplicate index dropped
- ram_wen  out  1  RAM write enable
- ram_wr_addr  out  AW  {wbank, in_idx}
- ram_wr_data  out  DW  = in_data
- ram_rd_addr  out  AW  {rbank, rd_cnt}
- ram_rd_data  in  DW  RAM read data, valid 1 cycle after address

Behaviour:
- Reset (async, rst=1):
  - wbank=0, rbank=0, both banks FREE, all written-bitmap bits 0, wr_cnt=0, rd_cnt=0.
  - Skid buffer empty, in-flight flag 0.
  - in_rdy=0 while rst asserted, 1 the first cycle after.
  - out_vld=0, dup_err=0, ram_wen=0.
- Bank state per bank, 2 bits: FREE (fillable), FULL (awaiting/under drain).
- Write side:
  - in_rdy = (bank[wbank]==FREE).
  - Accept = in_vld & in_rdy.
  - If bitmap[in_idx]==0: ram_wen=1 (combinational, same cycle), set bitmap bit, wr_cnt++.
  - If bitmap[in_idx]==1: ram_wen=0, nothing recorded, dup_err=1 next cycle for one cycle.
  - When the accept brings wr_cnt to BANK_DEPTH, at that edge:
    - bank[wbank]<=FULL, wbank toggles, bitmap and wr_cnt clear.
- Read side:
  - Drain active when bank[rbank]==FULL.
  - RAM read issued (ram_rd_addr={rbank,rd_cnt}) when drain active and (skid occupancy + in-flight) < 2; rd_cnt++ on issue.
  - On issuing rd_cnt==BANK_DEPTH-1, at that edge: bank[rbank]<=FREE, rbank toggles, rd_cnt<=0.
  - Read data is pushed into a 2-entry skid FIFO the cycle after issue; out_data/out_vld come from the skid head, registered.
  - Pop on out_vld & out_rdy. Pop and push in the same cycle are allowed.
- Latency:
  - Last write accepted at edge E: first read issued in cycle after E, data captured at E+2, out_vld=1 after E+2.
  - Sustained 1 word/cycle when out_rdy held high.
- Boundaries:
  - Both banks FULL: in_rdy=0 until the drain frees a bank.
  - A bank just freed is writable the next cycle. Write/read to the same bank can never coincide.
  - out_rdy low: reads stall with at most 2 words buffered, none lost.
  - in_idx wrap: index space is exactly BANK_DEPTH, no out-of-range possible.
  - Reset mid-frame: all partial data abandoned, banks FREE, skid flushed.

Decomposition:
- Package reorder_pkg: bank_state_e {FREE, FULL}; functions/localparams for BANK_DEPTH and bank/index address concatenation.
- Sub-module rd_skid2: 2-entry valid/ready skid FIFO with occupancy output, used for the RAM read-latency decoupling. The RAM itself (ram2p) is instantiated by the parent alongside this controller.

Test Plan (AW=3, BANK_DEPTH=4, DW=8):
- Write idx 3,1,0,2 with data 0xD3,0xD1,0xD0,0xD2, out_rdy=1 -> out sequence 0xD0,0xD1,0xD2,0xD3 back-to-back, first out_vld 2 cycles after last write edge.
- Write idx 1 twice (0xA1 then 0xEE), then 0,2,3 -> dup_err single pulse, ram_wen low on second write, output 0xA1 in slot 1.
- Fill bank0 and bank1 with out_rdy=0 -> in_rdy=0 after 8 accepts. Raise out_rdy -> in_rdy returns 1 the cycle after the 4th bank0 read issues.
- Toggle out_rdy 1/0 every cycle during drain -> all 4 words delivered in order, never more than 2 buffered, no duplication.
- Assert rst after 2 of 4 writes and again while out_vld=1 -> all outputs at reset values immediately. A fresh full frame afterwards drains correctly from bank0.
- Continuous streaming of 8 frames with random index permutations -> every frame output in order, in_rdy never deasserted with out_rdy=1.

Source files
------------

// File: rtl/reorder_pkg.sv
// Shared types and address helpers for the double-buffered reorder controller.
package reorder_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        FULL = 2'd1
    } bank_state_e;

    localparam int NUM_BANKS = 2;

    function automatic int unsigned bank_depth(input int unsigned aw);
        return 32'd1 << (aw - 1);
    endfunction

    // RAM address of an entry: the bank bit sits just above the index bits.
    function automatic int unsigned bank_addr(input logic bank, input int unsigned idx,
                                              input int unsigned aw);
        return ({31'd0, bank} << (aw - 1)) | idx;
    endfunction

endpackage

// File: rtl/rd_skid2.sv
// Two-entry FIFO that absorbs the RAM read latency so reads can stall without
// losing the word already in flight.
module rd_skid2 #(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          head_vld,
    output logic [DW-1:0] head_data,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          do_pop;

    assign do_pop = pop & (count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)   wr_ptr <= ~wr_ptr;
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_vld  = (count != 2'd0);
    assign head_data = mem[rd_ptr];
    assign occ       = count;

endmodule

// File: rtl/reorder_bank_ctrl.sv
// Double-buffered reorder controller: fills one RAM bank out of order by index
// while the other, completed bank is drained in index order.
module reorder_bank_ctrl
    import reorder_pkg::*;
#(
    parameter int DW = 18,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [AW-2:0] in_idx,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic          dup_err,
    output logic          ram_wen,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data
);

    localparam int              IW         = AW - 1;
    localparam int              BANK_DEPTH = int'(bank_depth(AW));
    localparam logic [IW-1:0]   LAST_IDX   = IW'(BANK_DEPTH - 1);

    bank_state_e           bank_st [NUM_BANKS];
    logic                  wbank;
    logic                  rbank;
    logic [BANK_DEPTH-1:0] bitmap;
    logic [IW-1:0]         wr_cnt;
    logic [IW-1:0]         rd_cnt;
    logic                  inflight;

    logic       accept;
    logic       is_dup;
    logic       new_wr;
    logic       wr_done;
    logic       drain;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] fill_lvl;
    logic       issue;
    logic       rd_done;

    // Write side: the bank being filled must be FREE; duplicates are dropped.
    assign in_rdy  = ~rst & (bank_st[wbank] == FREE);
    assign accept  = in_vld & in_rdy;
    assign is_dup  = bitmap[in_idx];
    assign new_wr  = accept & ~is_dup;
    assign wr_done = new_wr & (wr_cnt == LAST_IDX);

    assign ram_wen     = new_wr;
    assign ram_wr_addr = AW'(bank_addr(wbank, 32'(in_idx), AW));
    assign ram_wr_data = in_data;

    // Read side: the slot freed by this cycle's pop counts as available, which
    // keeps a full word per cycle flowing while the consumer is ready.
    assign drain    = (bank_st[rbank] == FULL);
    assign pop      = out_vld & out_rdy;
    assign fill_lvl = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight};
    assign issue    = drain & (fill_lvl < 3'd2);
    assign rd_done  = issue & (rd_cnt == LAST_IDX);

    assign ram_rd_addr = AW'(bank_addr(rbank, 32'(rd_cnt), AW));

    // NOTE: all state updates use <= so every branch sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            bitmap   <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            inflight <= 1'b0;
            dup_err  <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) bank_st[b] <= FREE;
        end else begin
            dup_err  <= accept & is_dup;
            inflight <= issue;

            if (wr_done) begin
                bank_st[wbank] <= FULL;
                wbank          <= ~wbank;
                bitmap         <= '0;
                wr_cnt         <= '0;
            end else if (new_wr) begin
                bitmap[in_idx] <= 1'b1;
                wr_cnt         <= wr_cnt + 1'b1;
            end

            // wbank is always FREE and rbank always FULL, so these never collide.
            if (rd_done) begin
                bank_st[rbank] <= FREE;
                rbank          <= ~rbank;
                rd_cnt         <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    rd_skid2 #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_rd_data),
        .pop       (out_rdy),
        .head_vld  (out_vld),
        .head_data (out_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_reorder_bank_ctrl.sv
// Directed bench for reorder_bank_ctrl with a small registered-read RAM model.
module tb_reorder_bank_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [AW-2:0] in_idx = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_data;
    logic          dup_err;
    logic          ram_wen;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    logic [DW-1:0] ram [2**AW];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] out_q [$];
    int            out_cyc [$];
    int            dup_cnt = 0;
    int            dup_cyc = -1;
    int            first_vld_cyc = -1;

    reorder_bank_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_idx      (in_idx),
        .in_data     (in_data),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .dup_err     (dup_err),
        .ram_wen     (ram_wen),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wen) ram[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= ram[ram_rd_addr];
    end

    // Observe transfers mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld && out_rdy) begin
                out_q.push_back(out_data);
                out_cyc.push_back(cyc);
            end
            if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (dup_err) begin
                dup_cnt++;
                dup_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_obs();
        out_q.delete();
        out_cyc.delete();
        first_vld_cyc = -1;
        dup_cnt = 0;
        dup_cyc = -1;
    endtask

    // Presents one write, waits (bounded) for acceptance, leaves time at edge+1.
    task automatic do_write(input logic [AW-2:0] idx, input logic [DW-1:0] d,
                            output logic wen, output logic [AW-1:0] waddr, output int waited);
        in_vld  = 1'b1;
        in_idx  = idx;
        in_data = d;
        waited  = 0;
        #1;
        while (!in_rdy && waited < 200) begin
            @(posedge clk);
            #2;
            waited++;
        end
        checks++;
        if (!in_rdy) begin
            errors++;
            $display("FAIL write_accept idx=%0d got in_rdy=%b want 1", idx, in_rdy);
        end
        wen   = ram_wen;
        waddr = ram_wr_addr;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input string tag);
        int budget = 0;
        while (out_q.size() < n && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checks++;
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL %s_count got %0d words want %0d", tag, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b1; in_idx = '0; in_data = 8'h55; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_rdy !== 1'b0)  begin errors++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL reset_dup_err got %b want 0", dup_err); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL reset_ram_wen got %b want 0", ram_wen); end
        @(posedge clk);
        #1;
        rst = 1'b0; in_vld = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b1)  begin errors++; $display("FAIL post_reset_in_rdy got %b want 1", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL post_reset_out_vld got %b want 0", out_vld); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_in_order();
        logic [AW-2:0] idxs [4];
        logic          wen;
        logic [AW-1:0] wa;
        int            w;
        int            last;
        idxs = '{2'd3, 2'd1, 2'd0, 2'd2};
        clear_obs();
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_write(idxs[i], 8'hD0 | 8'(idxs[i]), wen, wa, w);
            checks++; if (wen !== 1'b1) begin errors++; $display("FAIL order_wen i=%0d got %b want 1", i, wen); end
            checks++; if (wa !== {1'b0, idxs[i]}) begin errors++; $display("FAIL order_waddr i=%0d got %0d want %0d", i, wa, {1'b0, idxs[i]}); end
        end
        last = cyc;
        wait_outputs(4, "order");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== 8'hD0 + 8'(i)) begin
                errors++;
                $display("FAIL order_data i=%0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, 8'hD0 + 8'(i));
            end
            checks++;
            if (i >= out_cyc.size() || out_cyc[i] != last + 2 + i) begin
                errors++;
                $display("FAIL order_timing i=%0d got cyc %0d want %0d", i, (i < out_cyc.size()) ? out_cyc[i] : -1, last + 2 + i);
            end
        end
        checks++; if (first_vld_cyc != last + 2) begin errors++; $display("FAIL order_latency got %0d want %0d", first_vld_cyc, last + 2); end
    endtask

    task automatic test_dup();
        logic          wen;
        logic [AW-1:0] wa;
        int            w;
        int            dup_acc;
        logic [DW-1:0] exp [4];
        exp = '{8'hB0, 8'hA1, 8'hB2, 8'hB3};
        clear_obs();
        out_rdy = 1'b1;
        do_write(2'd1, 8'hA1, wen, wa, w);
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL dup_first_wen got %b want 1", wen); end
        checks++; if (wa !== 3'd5) begin errors++; $display("FAIL dup_first_waddr got %0d want 5", wa); end
        do_write(2'd1, 8'hEE, wen, wa, w);
        dup_acc = cyc;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL dup_second_wen got %b want 0", wen); end
        do_write(2'd0, 8'hB0, wen, wa, w);
        do_write(2'd2, 8'hB2, wen, wa, w);
        do_write(2'd3, 8'hB3, wen, wa, w);
        wait_outputs(4, "dup");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL dup_data i=%0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dup_cnt != 1) begin errors++; $display("FAIL dup_pulse_count got %0d want 1", dup_cnt); end
        checks++; if (dup_cyc != dup_acc) begin errors++; $display("FAIL dup_pulse_cycle got %0d want %0d", dup_cyc, dup_acc); end
    endtask

    task automatic test_both_full();
        logic          wen;
        logic [AW-1:0] wa;
        int            w;
        clear_obs();
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) do_write(2'(i), 8'h10 + 8'(i), wen, wa, w);
        for (int i = 3; i >= 0; i--) do_write(2'(i), 8'h20 + 8'(i), wen, wa, w);
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_in_rdy got %b want 0", in_rdy); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (in_rdy !== 1'b0)     begin errors++; $display("FAIL full_hold_in_rdy got %b want 0", in_rdy); end
        checks++; if (out_vld !== 1'b1)    begin errors++; $display("FAIL full_out_vld got %b want 1", out_vld); end
        checks++; if (out_data !== 8'h10)  begin errors++; $display("FAIL full_head got %h want 10", out_data); end
        checks++; if (out_q.size() != 0)   begin errors++; $display("FAIL full_no_transfer got %0d words want 0", out_q.size()); end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL release_c0_in_rdy got %b want 0", in_rdy); end
        @(posedge clk);
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL release_c1_in_rdy got %b want 0", in_rdy); end
        @(posedge clk);
        #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL release_c2_in_rdy got %b want 1", in_rdy); end
        wait_outputs(8, "full");
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] e;
            e = (i < 4) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 4);
            checks++;
            if (i >= out_q.size() || out_q[i] !== e) begin
                errors++;
                $display("FAIL full_data i=%0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, e);
            end
        end
    endtask

    task automatic test_toggle();
        logic          wen;
        logic [AW-1:0] wa;
        int            w;
        logic [AW-2:0] idxs [4];
        idxs = '{2'd2, 2'd0, 2'd3, 2'd1};
        clear_obs();
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) do_write(idxs[i], 8'h30 + 8'(idxs[i]), wen, wa, w);
        for (int i = 0; i < 20; i++) begin
            out_rdy = (i % 2 == 1);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        wait_outputs(4, "toggle");
        repeat (10) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL toggle_total got %0d words want 4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== 8'h30 + 8'(i)) begin
                errors++;
                $display("FAIL toggle_data i=%0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, 8'h30 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic          wen;
        logic [AW-1:0] wa;
        int            w;
        int            budget;
        int            last;
        logic [AW-2:0] idxs [4];
        idxs = '{2'd1, 2'd3, 2'd0, 2'd2};
        out_rdy = 1'b1;
        do_write(2'd0, 8'h60, wen, wa, w);
        do_write(2'd1, 8'h61, wen, wa, w);
        in_vld = 1'b1; in_idx = 2'd2; in_data = 8'h62;
        rst = 1'b1;
        #1;
        checks++; if (in_rdy !== 1'b0)  begin errors++; $display("FAIL midreset_in_rdy got %b want 0", in_rdy); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL midreset_ram_wen got %b want 0", ram_wen); end
        @(posedge clk);
        #1;
        rst = 1'b0; in_vld = 1'b0;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) do_write(2'(i), 8'h70 + 8'(i), wen, wa, w);
        budget = 0;
        while (!out_vld && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL prereset_out_vld got %b want 1", out_vld); end
        rst = 1'b1;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL outreset_out_vld got %b want 0", out_vld); end
        checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL outreset_dup_err got %b want 0", dup_err); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_write(idxs[i], 8'h50 + 8'(idxs[i]), wen, wa, w);
            checks++; if (wa !== {1'b0, idxs[i]}) begin errors++; $display("FAIL fresh_waddr i=%0d got %0d want %0d", i, wa, {1'b0, idxs[i]}); end
        end
        last = cyc;
        wait_outputs(4, "fresh");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== 8'h50 + 8'(i)) begin
                errors++;
                $display("FAIL fresh_data i=%0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, 8'h50 + 8'(i));
            end
        end
        checks++; if (first_vld_cyc != last + 2) begin errors++; $display("FAIL fresh_latency got %0d want %0d", first_vld_cyc, last + 2); end
    endtask

    task automatic test_stream();
        logic          wen;
        logic [AW-1:0] wa;
        int            w;
        int            perm [4];
        int            j;
        int            tmp;
        int            stalls = 0;
        int            misses = 0;
        clear_obs();
        out_rdy = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) perm[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int k = 0; k < 4; k++) begin
                do_write(2'(perm[k]), 8'(f * 16 + perm[k]), wen, wa, w);
                if (w != 0) stalls++;
                if (wen !== 1'b1) misses++;
            end
        end
        checks++; if (stalls != 0) begin errors++; $display("FAIL stream_in_rdy got %0d stalled writes want 0", stalls); end
        checks++; if (misses != 0) begin errors++; $display("FAIL stream_wen got %0d dropped writes want 0", misses); end
        wait_outputs(32, "stream");
        for (int i = 0; i < 32; i++) begin
            logic [DW-1:0] e;
            e = 8'((i / 4) * 16 + (i % 4));
            checks++;
            if (i >= out_q.size() || out_q[i] !== e) begin
                errors++;
                $display("FAIL stream_data i=%0d got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, e);
            end
        end
        checks++; if (dup_cnt != 0) begin errors++; $display("FAIL stream_dup got %0d pulses want 0", dup_cnt); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_dup();
        test_both_full();
        test_toggle();
        test_reset_mid();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
